// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam int unsigned LaneW    = 8;
  localparam int unsigned MaxDataW = 1024;
  localparam int unsigned MaxLanes = MaxDataW / LaneW;

  // Callers zero-extend to MaxDataW and keep the low DATA_W bits of the result.
  function automatic logic [MaxDataW-1:0] byte_merge(input logic [MaxDataW-1:0] old_data,
                                                     input logic [MaxDataW-1:0] wdata,
                                                     input logic [MaxLanes-1:0] be);
    logic [MaxDataW-1:0] merged;
    merged = old_data;
    for (int i = 0; i < MaxLanes; i++) begin
      if (be[i]) merged[i*LaneW +: LaneW] = wdata[i*LaneW +: LaneW];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_hs_if.sv
// Request/response valid-ready bundle between the load/store unit and dmem_hs.
interface dmem_hs_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) ();

  localparam int unsigned Lanes = DATA_W / dmem_pkg::LaneW;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [Lanes-1:0]  req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              init_done;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with byte-lane write enables and registered,
// read-before-write read data.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [DATA_W/LaneW-1:0]  be,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  localparam int unsigned Lanes = DATA_W / LaneW;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [MaxDataW-1:0] old_w;
  logic [MaxDataW-1:0] new_w;
  logic [MaxDataW-1:0] merged_w;
  logic [MaxLanes-1:0] be_w;
  logic                unused_merged;

  always_comb begin
    old_w                = '0;
    new_w                = '0;
    be_w                 = '0;
    old_w[DATA_W-1:0]    = mem[addr];
    new_w[DATA_W-1:0]    = wdata;
    be_w[Lanes-1:0]      = be;
    merged_w             = byte_merge(old_w, new_w, be_w);
  end

  assign unused_merged = ^merged_w;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= merged_w[DATA_W-1:0];
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_hs.sv
// Handshaked word-addressed data memory: init sweep, wait states, byte lanes,
// bounds-error responses; one outstanding transaction at a time.
module dmem_hs
  import dmem_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       DEPTH       = 256,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [DATA_W-1:0] INIT0       = DATA_W'(16'h02BC)
) (
  input logic       clk,
  input logic       rst,
  dmem_hs_if.slave  bus
);

  localparam int unsigned       LANES    = DATA_W / LaneW;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]        WaitCnt  = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LANES-1:0]  be_q, be_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_load_q, rsp_load_d;
  logic              init_done_q, init_done_d;

  logic              in_range;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [LANES-1:0]  arr_be;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign in_range = ({1'b0, addr_q} < DepthW);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_err_d   = rsp_err_q;
    rsp_load_d  = rsp_load_q;
    init_done_d = init_done_q;
    arr_we      = 1'b0;
    arr_addr    = addr_q;
    arr_be      = be_q;
    arr_wdata   = wdata_q;

    unique case (state_q)
      ST_INIT: begin
        arr_we    = 1'b1;
        arr_addr  = ptr_q;
        arr_be    = '1;
        arr_wdata = (ptr_q == '0) ? INIT0 : '0;
        ptr_d     = ptr_q + ADDR_W'(1);
        if (ptr_q == LastAddr) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          cnt_d   = WaitCnt;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The last WAIT cycle presents the latched access so the registered
        // array commits/reads on the edge into RESP (WAIT_CYCLES+1 after accept).
        if (cnt_q == '0) begin
          arr_we     = write_q && in_range;
          rsp_err_d  = !in_range;
          rsp_load_d = !write_q && in_range;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_err_d  = 1'b0;
          rsp_load_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ptr_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
      init_done_q <= init_done_d;
    end
  end

  // The array has no reset, so a write must not land on a reset edge.
  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we && !rst),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Array read data stays put through RESP: no writes, address held.
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rsp_load_q ? arr_rdata : '0;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.init_done = init_done_q;

endmodule
